xbee_uart_tx: RTL

XBEE_UART_TX -- requirements
Module: xbee_uart_tx

---
 rtl/xbee_pkg.sv | 38 +++
 rtl/xbee_baud_gen.sv | 35 +++
 rtl/xbee_uart_tx.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/xbee_pkg.sv
// xbee_pkg: definitions shared by the XBee UART transmitter and receiver.
// Optional build macro: XBEE_UART_TX_PARITY_EN adds the even-parity bit state.
package xbee_pkg;

  // Payload width of one serial character.
  localparam int DATA_BITS       = 8;

  // Bit period in clk cycles: 9600 baud from a 50 MHz clock.
  localparam int DEFAULT_CLK_DIV = 5208;

  // Width of the bit-period counter. It covers the full legal CLK_DIV range.
  localparam int BAUD_CNT_W      = 16;

`ifdef XBEE_UART_TX_PARITY_EN
  // The frame walks IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } xbee_state_e;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction
`else
  // The frame walks IDLE -> START -> DATA -> STOP -> IDLE (8N1 / 8N2).
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } xbee_state_e;
`endif

endpackage

// File: rtl/xbee_baud_gen.sv
// xbee_baud_gen: bit-period timer for the XBee UART.
// bit_end pulses for one clk at the last cycle of every CLK_DIV-cycle period.
// restart forces the count back to zero, so the next period starts on the
// following cycle and lasts exactly CLK_DIV cycles.
module xbee_baud_gen
  import xbee_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic bit_end
);

  localparam logic [BAUD_CNT_W-1:0] LAST = BAUD_CNT_W'(CLK_DIV - 1);

  logic [BAUD_CNT_W-1:0] cnt;

  // The strobe marks the final cycle of a period. It is masked while the
  // timer is held in restart so a stale count never ends a bit early.
  assign bit_end = (cnt == LAST) && !restart;

  // The period counter wraps at CLK_DIV-1 and is cleared by restart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + BAUD_CNT_W'(1);
    end
  end

endmodule

// File: rtl/xbee_uart_tx.sv
// xbee_uart_tx: UART transmitter feeding the XBee DIN pin.
// A one-byte holding register sits in front of an 8-bit shift register, so
// the next byte can be queued while the current frame is on the line.
// The frame is a start bit, 8 data bits sent LSB first, an optional even-parity
// bit, and STOP_BITS stop bits. Each bit lasts CLK_DIV clk cycles.
// Optional build macro: XBEE_UART_TX_PARITY_EN inserts the parity bit.
module xbee_uart_tx
  import xbee_pkg::*;
#(
  parameter int CLK_DIV   = DEFAULT_CLK_DIV,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] Din,
  input  logic       Send,
  output logic       Ready,
  output logic       Busy,
  output logic       Done,
  output logic       Tx
);

  // The stop-bit counter is one bit wide. The last stop bit is reached when
  // it equals this value (0 for one stop bit, 1 for two).
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  xbee_state_e           state, state_nxt;

  logic [DATA_BITS-1:0]  hold_q;
  logic                  hold_full;
  logic [DATA_BITS-1:0]  shift_q;
  logic [2:0]            bit_idx;
  logic                  stop_cnt;
  logic                  done_q;
  logic                  bit_end;
  logic                  baud_restart;
  logic                  load;
  logic                  data_last;
  logic                  stop_end;
`ifdef XBEE_UART_TX_PARITY_EN
  logic                  par_q;
`endif

  // Frame start: in IDLE with a byte waiting, the byte moves into the shifter.
  assign load      = (state == ST_IDLE) && hold_full;

  // The last data bit ends when the 3-bit index is about to wrap 7 -> 0.
  assign data_last = (state == ST_DATA) && bit_end && (bit_idx == 3'd7);

  // The last stop bit ends here. Done fires and the FSM returns to IDLE.
  assign stop_end  = (state == ST_STOP) && bit_end && (stop_cnt == STOP_LAST);

  // The timer is held in restart throughout IDLE. The START edge therefore
  // begins a fresh period of exactly CLK_DIV cycles.
  assign baud_restart = (state == ST_IDLE);

  xbee_baud_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (baud_restart),
    .bit_end (bit_end)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic. Every non-IDLE state advances on the bit-end strobe.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (hold_full) state_nxt = ST_START;
      ST_START:  if (bit_end)   state_nxt = ST_DATA;
`ifdef XBEE_UART_TX_PARITY_EN
      ST_DATA:   if (data_last) state_nxt = ST_PARITY;
      ST_PARITY: if (bit_end)   state_nxt = ST_STOP;
`else
      ST_DATA:   if (data_last) state_nxt = ST_STOP;
`endif
      ST_STOP:   if (stop_end)  state_nxt = ST_IDLE;
      default:                  state_nxt = ST_IDLE;
    endcase
  end

  // Line and status outputs, decoded from the state. Reset forces the line
  // high at once because it drives the state to IDLE asynchronously.
  always_comb begin
    Tx   = 1'b1;
    Busy = (state != ST_IDLE);
    case (state)
      ST_START:  Tx = 1'b0;
      ST_DATA:   Tx = shift_q[0];
`ifdef XBEE_UART_TX_PARITY_EN
      ST_PARITY: Tx = par_q;
`endif
      default:   Tx = 1'b1;
    endcase
  end

  assign Ready = !hold_full;
  assign Done  = done_q;

  // Holding register. A byte is accepted only while the register is empty.
  // The register empties only when load fires, which needs it full, so an
  // accept and an unload can never fall on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q    <= '0;
      hold_full <= 1'b0;
    end else if (load) begin
      hold_full <= 1'b0;
    end else if (Send && !hold_full) begin
      hold_q    <= Din;
      hold_full <= 1'b1;
    end
  end

  // Shift register and bit counters. Both restart at frame start. Data goes
  // out LSB first by shifting right at the end of each data bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q  <= '0;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
    end else if (load) begin
      shift_q  <= hold_q;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
    end else if ((state == ST_DATA) && bit_end) begin
      shift_q  <= shift_q >> 1;
      bit_idx  <= bit_idx + 3'd1;
    end else if ((state == ST_STOP) && bit_end) begin
      stop_cnt <= stop_cnt + 1'b1;
    end
  end

`ifdef XBEE_UART_TX_PARITY_EN
  // Parity is taken from the byte as it is loaded, because the shifter
  // no longer holds the whole byte by the time the parity bit goes out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    par_q <= 1'b0;
    else if (load) par_q <= even_parity(hold_q);
  end
`endif

  // Done is a registered one-cycle pulse. It is set on the edge that
  // returns the FSM to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done_q <= 1'b0;
    else        done_q <= stop_end;
  end

endmodule
